// File: rtl/ssm_ctrl_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, state encoding,
// one-hot sub-FSM selects and the watchdog limit.
package ssm_ctrl_pkg;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_MOV = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_START  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RETIRE = 3'd4
   } state_t;

   localparam int FSM_IDX_MOV = 0;
   localparam int FSM_IDX_ADD = 1;
   localparam int FSM_IDX_SUB = 2;
   localparam int FSM_IDX_XOR = 3;

   localparam logic [3:0] SEL_MOV = 4'b0001;
   localparam logic [3:0] SEL_ADD = 4'b0010;
   localparam logic [3:0] SEL_SUB = 4'b0100;
   localparam logic [3:0] SEL_XOR = 4'b1000;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

   // One-hot sub-FSM select for an opcode; zero for NOP and illegal opcodes.
   function automatic logic [3:0] op_to_sel(input logic [3:0] op);
      logic [3:0] sel;
      sel = 4'b0000;
      case (op)
         OP_MOV:  sel = SEL_MOV;
         OP_ADD:  sel = SEL_ADD;
         OP_SUB:  sel = SEL_SUB;
         OP_XOR:  sel = SEL_XOR;
         default: sel = 4'b0000;
      endcase
      return sel;
   endfunction

   function automatic logic op_is_illegal(input logic [3:0] op);
      return (op > OP_XOR);
   endfunction

endpackage

// File: rtl/fsm_watchdog.sv
// Watchdog for the WAIT state: cleared on WAIT entry, counts each WAIT cycle
// and flags expiry once the count sits at the limit.
module fsm_watchdog
   import ssm_ctrl_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   output logic       expired,
   output logic [7:0] count
);

   assign expired = (count == TIMEOUT_LIMIT);

   // Count WAIT cycles; hold at the limit so the counter never wraps.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= 8'd0;
      end else if (clear) begin
         count <= 8'd0;
      end else if (enable && !expired) begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: accepts one instruction word at a time, dispatches
// it to one of four sub-FSMs, waits for its done and retires it.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | ready for a new instruction
//   DECODE | latched opcode inspected; illegal_op pulses here if undefined
//   START  | one-cycle FSM_start to the selected sub-FSM, bus granted
//   WAIT   | bus granted, waiting for the selected done bit or watchdog
//   RETIRE | retire pulse, retired_count advances
module instruction_sequencer
   import ssm_ctrl_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [15:0] instruction,
   output logic        instr_ready,
   output logic [3:0]  FSM_start,
   input  logic [3:0]  FSM_done,
   output logic [5:0]  param1,
   output logic [5:0]  param2,
   output logic [3:0]  bus_owner,
   output logic        retire,
   output logic        illegal_op,
   output logic        timeout,
   output logic [15:0] retired_count,
   output logic        busy
);

   state_t     state;
   logic [3:0] opcode;
   logic [3:0] sel;
   logic       wd_expired;
   logic [7:0] wd_count;

   assign instr_ready = (state == ST_IDLE);
   assign busy        = (state != ST_IDLE);

   fsm_watchdog u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (state == ST_START),
      .enable  (state == ST_WAIT),
      .expired (wd_expired),
      .count   (wd_count)
   );

   // Sequencer state machine with registered pulse, select and grant outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_IDLE;
         opcode        <= OP_NOP;
         sel           <= 4'b0000;
         param1        <= 6'd0;
         param2        <= 6'd0;
         FSM_start     <= 4'b0000;
         bus_owner     <= 4'b0000;
         retire        <= 1'b0;
         illegal_op    <= 1'b0;
         timeout       <= 1'b0;
         retired_count <= 16'd0;
      end else begin
         FSM_start  <= 4'b0000;
         retire     <= 1'b0;
         illegal_op <= 1'b0;
         timeout    <= 1'b0;
         case (state)
            ST_IDLE: begin
               bus_owner <= 4'b0000;
               if (instr_valid) begin
                  opcode     <= instruction[15:12];
                  sel        <= op_to_sel(instruction[15:12]);
                  param1     <= instruction[11:6];
                  param2     <= instruction[5:0];
                  illegal_op <= op_is_illegal(instruction[15:12]);
                  state      <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (opcode == OP_NOP) begin
                  retire <= 1'b1;
                  state  <= ST_RETIRE;
               end else if (sel != 4'b0000) begin
                  FSM_start <= sel;
                  bus_owner <= sel;
                  state     <= ST_START;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_START: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if ((FSM_done & sel) != 4'b0000) begin
                  retire    <= 1'b1;
                  bus_owner <= 4'b0000;
                  state     <= ST_RETIRE;
               end else if (wd_expired) begin
                  timeout   <= 1'b1;
                  bus_owner <= 4'b0000;
                  state     <= ST_IDLE;
               end
            end
            ST_RETIRE: begin
               retired_count <= retired_count + 16'd1;
               state         <= ST_IDLE;
            end
            default: begin
               bus_owner <= 4'b0000;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer; outputs sampled 1 time unit
// after each rising edge.
module tb_instruction_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [15:0] instruction;
   logic        instr_ready;
   logic [3:0]  FSM_start;
   logic [3:0]  FSM_done;
   logic [5:0]  param1;
   logic [5:0]  param2;
   logic [3:0]  bus_owner;
   logic        retire;
   logic        illegal_op;
   logic        timeout;
   logic [15:0] retired_count;
   logic        busy;

   int errors = 0;
   int checks = 0;

   instruction_sequencer dut (
      .clock         (clock),
      .reset         (reset),
      .instr_valid   (instr_valid),
      .instruction   (instruction),
      .instr_ready   (instr_ready),
      .FSM_start     (FSM_start),
      .FSM_done      (FSM_done),
      .param1        (param1),
      .param2        (param2),
      .bus_owner     (bus_owner),
      .retire        (retire),
      .illegal_op    (illegal_op),
      .timeout       (timeout),
      .retired_count (retired_count),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, " instr_ready"}, {15'd0, instr_ready}, 16'd1);
      chk({tag, " busy"}, {15'd0, busy}, 16'd0);
      chk({tag, " FSM_start"}, {12'd0, FSM_start}, 16'd0);
      chk({tag, " bus_owner"}, {12'd0, bus_owner}, 16'd0);
      chk({tag, " param1"}, {10'd0, param1}, 16'd0);
      chk({tag, " param2"}, {10'd0, param2}, 16'd0);
      chk({tag, " retire"}, {15'd0, retire}, 16'd0);
      chk({tag, " illegal_op"}, {15'd0, illegal_op}, 16'd0);
      chk({tag, " timeout"}, {15'd0, timeout}, 16'd0);
      chk({tag, " retired_count"}, retired_count, 16'd0);
      chk({tag, " watchdog"}, {8'd0, dut.u_watchdog.count}, 16'd0);
   endtask

   initial begin
      reset       = 1'b1;
      instr_valid = 1'b0;
      instruction = 16'h0000;
      FSM_done    = 4'b0000;
      tick();
      tick();
      chk_reset_values("reset");
      reset = 1'b0;

      // MOV 16'h1078, done[0] in the third WAIT cycle
      instruction = 16'h1078;
      instr_valid = 1'b1;
      tick();
      chk("mov decode busy", {15'd0, busy}, 16'd1);
      chk("mov decode ready", {15'd0, instr_ready}, 16'd0);
      chk("mov param1", {10'd0, param1}, 16'h0001);
      chk("mov param2", {10'd0, param2}, 16'h0038);
      chk("mov decode start", {12'd0, FSM_start}, 16'd0);
      instr_valid = 1'b0;
      instruction = 16'hFFFF;
      tick();
      chk("mov start pulse", {12'd0, FSM_start}, 16'h0001);
      chk("mov start owner", {12'd0, bus_owner}, 16'h0001);
      tick();
      chk("mov wait1 start", {12'd0, FSM_start}, 16'd0);
      chk("mov wait1 owner", {12'd0, bus_owner}, 16'h0001);
      chk("mov wait1 wd", {8'd0, dut.u_watchdog.count}, 16'd0);
      tick();
      chk("mov wait2 start", {12'd0, FSM_start}, 16'd0);
      tick();
      chk("mov wait3 owner", {12'd0, bus_owner}, 16'h0001);
      chk("mov wait3 retire", {15'd0, retire}, 16'd0);
      FSM_done = 4'b0001;
      tick();
      FSM_done = 4'b0000;
      chk("mov retire pulse", {15'd0, retire}, 16'd1);
      chk("mov retire owner", {12'd0, bus_owner}, 16'd0);
      chk("mov retire start", {12'd0, FSM_start}, 16'd0);
      tick();
      chk("mov retire end", {15'd0, retire}, 16'd0);
      chk("mov count", retired_count, 16'd1);
      chk("mov ready", {15'd0, instr_ready}, 16'd1);
      chk("mov param1 hold", {10'd0, param1}, 16'h0001);
      chk("mov param2 hold", {10'd0, param2}, 16'h0038);

      // NOP: retire two edges after accept, ready on the third
      instruction = 16'h0000;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      chk("nop decode ready", {15'd0, instr_ready}, 16'd0);
      chk("nop param1", {10'd0, param1}, 16'd0);
      tick();
      chk("nop retire", {15'd0, retire}, 16'd1);
      chk("nop start", {12'd0, FSM_start}, 16'd0);
      chk("nop retire ready", {15'd0, instr_ready}, 16'd0);
      tick();
      chk("nop ready", {15'd0, instr_ready}, 16'd1);
      chk("nop count", retired_count, 16'd2);

      // Illegal opcode
      instruction = 16'hF000;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      chk("ill pulse", {15'd0, illegal_op}, 16'd1);
      chk("ill busy", {15'd0, busy}, 16'd1);
      tick();
      chk("ill pulse end", {15'd0, illegal_op}, 16'd0);
      chk("ill start", {12'd0, FSM_start}, 16'd0);
      chk("ill ready", {15'd0, instr_ready}, 16'd1);
      chk("ill count", retired_count, 16'd2);

      // ADD with the wrong done bit high
      instruction = 16'h2041;
      instr_valid = 1'b1;
      FSM_done    = 4'b0001;
      tick();
      instr_valid = 1'b0;
      chk("add param1", {10'd0, param1}, 16'h0001);
      chk("add param2", {10'd0, param2}, 16'h0001);
      tick();
      chk("add start", {12'd0, FSM_start}, 16'h0002);
      chk("add owner", {12'd0, bus_owner}, 16'h0002);
      tick();
      tick();
      chk("add wrong done busy", {15'd0, busy}, 16'd1);
      chk("add wrong done retire", {15'd0, retire}, 16'd0);
      chk("add wrong done owner", {12'd0, bus_owner}, 16'h0002);
      FSM_done = 4'b0011;
      tick();
      FSM_done = 4'b0000;
      chk("add retire", {15'd0, retire}, 16'd1);
      tick();
      chk("add count", retired_count, 16'd3);

      // SUB timeout
      instruction = 16'h3000;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      chk("sub start", {12'd0, FSM_start}, 16'h0004);
      tick();
      chk("sub wd clear", {8'd0, dut.u_watchdog.count}, 16'd0);
      for (int i = 0; i < 255; i++) tick();
      chk("sub wd 255", {8'd0, dut.u_watchdog.count}, 16'd255);
      chk("sub still waiting", {15'd0, busy}, 16'd1);
      chk("sub no early timeout", {15'd0, timeout}, 16'd0);
      tick();
      chk("sub timeout pulse", {15'd0, timeout}, 16'd1);
      chk("sub timeout idle", {15'd0, instr_ready}, 16'd1);
      chk("sub timeout no retire", {15'd0, retire}, 16'd0);
      chk("sub timeout owner", {12'd0, bus_owner}, 16'd0);
      chk("sub timeout count", retired_count, 16'd3);
      tick();
      chk("sub timeout end", {15'd0, timeout}, 16'd0);

      // SUB with done arriving at count 255
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 255; i++) tick();
      chk("sub2 wd 255", {8'd0, dut.u_watchdog.count}, 16'd255);
      FSM_done = 4'b0100;
      tick();
      FSM_done = 4'b0000;
      chk("sub2 retire", {15'd0, retire}, 16'd1);
      chk("sub2 no timeout", {15'd0, timeout}, 16'd0);
      tick();
      chk("sub2 count", retired_count, 16'd4);
      chk("sub2 no timeout idle", {15'd0, timeout}, 16'd0);

      // XOR interrupted by reset mid-WAIT
      instruction = 16'h4FC3;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      chk("xor param1", {10'd0, param1}, 16'h003F);
      chk("xor param2", {10'd0, param2}, 16'h0003);
      tick();
      chk("xor start", {12'd0, FSM_start}, 16'h0008);
      tick();
      tick();
      chk("xor wait owner", {12'd0, bus_owner}, 16'h0008);
      reset = 1'b1;
      tick();
      chk_reset_values("xor reset");
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("xor no restart", {12'd0, FSM_start}, 16'd0);
      end

      // 65536 back-to-back NOPs wrap the retire counter
      instruction = 16'h0000;
      instr_valid = 1'b1;
      for (int i = 0; i < 65535 * 3; i++) tick();
      chk("wrap ffff", retired_count, 16'hFFFF);
      tick();
      tick();
      tick();
      instr_valid = 1'b0;
      chk("wrap zero", retired_count, 16'h0000);
      chk("wrap ready", {15'd0, instr_ready}, 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
